// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if: keypad pins and debounced key bundle.
// master = scanner (drives rows, key outputs); slave = board/consumer side.
interface keypad_matrix_scanner_if;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] key;
  logic        key_any;
  logic        key_event;

  modport master (
    input  col_in,
    output row_out,
    output key,
    output key_any,
    output key_event
  );

  modport slave (
    output col_in,
    input  row_out,
    input  key,
    input  key_any,
    input  key_event
  );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: 4x4 active-low keypad scan with frame debounce.
// Ports: clk1k, rst_n (sync, active-low), kp (col_in in; row_out, key[15:0],
// key_any, key_event out). Optional KEYPAD_GHOST_REJECT_EN drops frames
// with three or more keys down (possible matrix ghosting).
module keypad_matrix_scanner #(
  parameter int SCAN_TICKS = 4,
  parameter int DEB_FRAMES = 2
) (
  input logic                     clk1k,
  input logic                     rst_n,
  keypad_matrix_scanner_if.master kp
);

  localparam logic [3:0] T_LAST = 4'(SCAN_TICKS - 1);
  localparam logic [3:0] DEB_L  = 4'(DEB_FRAMES);

  logic [1:0]  r_q, r_d;
  logic [3:0]  t_q, t_d;
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [11:0] raw_q, raw_d;
  logic [15:0] last_cand_q, last_cand_d;
  logic [3:0]  stable_cnt_q, stable_cnt_d;
  logic [15:0] key_q, key_d;
  logic        key_any_q, key_any_d;
  logic        key_event_q, key_event_d;

  logic [3:0]  colsync;
  logic [15:0] cand;
  logic [3:0]  cnt_inc;
  logic [3:0]  new_cnt;
  logic        sample;
  logic        frame_end;
  logic        ghost;

  always_comb begin
    sync1_d      = kp.col_in;
    sync2_d      = sync1_q;
    r_d          = r_q;
    t_d          = t_q;
    raw_d        = raw_q;
    last_cand_d  = last_cand_q;
    stable_cnt_d = stable_cnt_q;
    key_d        = key_q;
    key_any_d    = key_any_q;
    key_event_d  = 1'b0;

    colsync   = ~sync2_q;
    sample    = (t_q == T_LAST);
    frame_end = sample && (r_q == 2'd3);
    // Row 3 columns go straight into cand, never via raw.
    cand      = {colsync, raw_q};
    cnt_inc   = (stable_cnt_q == 4'hF) ?
                4'hF : stable_cnt_q + 4'd1;
    new_cnt   = (cand == last_cand_q) ? cnt_inc : 4'd1;

`ifdef KEYPAD_GHOST_REJECT_EN
    ghost = ($countones(cand) >= 3);
`else
    ghost = 1'b0;
`endif

    if (sample) begin
      t_d = 4'd0;
      r_d = r_q + 2'd1;
      unique case (r_q)
        2'd0:    raw_d[3:0]  = colsync;
        2'd1:    raw_d[7:4]  = colsync;
        2'd2:    raw_d[11:8] = colsync;
        default: raw_d       = raw_q;
      endcase
    end else begin
      t_d = t_q + 4'd1;
    end

    if (frame_end) begin
      if (ghost) begin
        stable_cnt_d = 4'd0;
      end else begin
        last_cand_d  = cand;
        stable_cnt_d = new_cnt;
        if (new_cnt >= DEB_L && cand != key_q) begin
          key_d       = cand;
          key_any_d   = |cand;
          key_event_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk1k) begin
    if (!rst_n) begin
      r_q          <= 2'd0;
      t_q          <= 4'd0;
      sync1_q      <= 4'hF;
      sync2_q      <= 4'hF;
      raw_q        <= '0;
      last_cand_q  <= '0;
      stable_cnt_q <= 4'd0;
      key_q        <= '0;
      key_any_q    <= 1'b0;
      key_event_q  <= 1'b0;
    end else begin
      r_q          <= r_d;
      t_q          <= t_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      raw_q        <= raw_d;
      last_cand_q  <= last_cand_d;
      stable_cnt_q <= stable_cnt_d;
      key_q        <= key_d;
      key_any_q    <= key_any_d;
      key_event_q  <= key_event_d;
    end
  end

  assign kp.row_out   = ~(4'b0001 << r_q);
  assign kp.key       = key_q;
  assign kp.key_any   = key_any_q;
  assign kp.key_event = key_event_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: keypad model + scoreboard bench.
// Expected key vectors are queued by stimulus, popped on key_event.
module tb_keypad_matrix_scanner;

  logic clk1k = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1k = ~clk1k;

  keypad_matrix_scanner_if kif ();

  keypad_matrix_scanner dut (
    .clk1k (clk1k),
    .rst_n (rst_n),
    .kp    (kif)
  );

  logic [15:0] pressed = '0;
  logic [3:0]  col_m;

  always_comb begin
    col_m = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!kif.row_out[r])
        col_m = col_m & ~pressed[r*4 +: 4];
  end
  assign kif.col_in = col_m;

  int total = 0;
  int bad   = 0;
  logic [15:0] expq[$];
  logic [15:0] mon_exp;

  always @(negedge clk1k) begin
    if (kif.key_event === 1'b1) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event key=%h want=no_event",
                 kif.key);
      end else begin
        mon_exp = expq.pop_front();
        if (kif.key !== mon_exp) begin
          bad++;
          $display("FAIL event_key got=%h want=%h",
                   kif.key, mon_exp);
        end
        total++;
        if (kif.key_any !== (|mon_exp)) begin
          bad++;
          $display("FAIL event_key_any got=%b want=%b",
                   kif.key_any, |mon_exp);
        end
      end
    end
  end

  task automatic chk(string nm, logic [15:0] act,
                     logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Return at the negedge of the first cycle of row 0.
  task automatic align();
    int n;
    logic [3:0] prev;
    n = 0;
    prev = kif.row_out;
    @(negedge clk1k);
    while (!(kif.row_out == 4'b1110 && prev != 4'b1110)
           && n < 100) begin
      prev = kif.row_out;
      @(negedge clk1k);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL align_timeout row_out=%b want=1110",
               kif.row_out);
    end
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 48) begin
      @(negedge clk1k);
      n++;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL %s_latency pending=%0d want=0",
               nm, expq.size());
      expq.delete();
    end
  endtask

  task automatic settle(int frames);
    repeat (frames * 16) @(negedge clk1k);
  endtask

  task automatic press(logic [15:0] p, string nm);
    align();
    pressed = p;
    expq.push_back(p);
    drain(nm);
    chk({nm, "_key"}, kif.key, p);
    chk({nm, "_any"}, {15'd0, kif.key_any}, {15'd0, |p});
    settle(3);
  endtask

  logic [3:0] one;
  int n6;

  initial begin
    one = 4'b0001;
    rst_n = 1'b0;
    repeat (3) @(posedge clk1k);
    @(negedge clk1k);
    chk("rst_row", {12'd0, kif.row_out}, 16'h000E);
    chk("rst_key", kif.key, 16'h0000);
    chk("rst_any", {15'd0, kif.key_any}, 16'h0000);
    chk("rst_evt", {15'd0, kif.key_event}, 16'h0000);
    rst_n = 1'b1;
    chk("rel_row", {12'd0, kif.row_out}, 16'h000E);
    for (int i = 1; i <= 4; i++) begin
      repeat (4) @(posedge clk1k);
      @(negedge clk1k);
      chk("row_step", {12'd0, kif.row_out},
          {12'd0, ~(one << (i % 4))});
    end

    press(16'h0040, "t2_press");
    settle(1);
    press(16'h0000, "t2_release");

    align();
    for (int i = 0; i < 12; i++) begin
      pressed = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      repeat (5) @(negedge clk1k);
    end
    chk("t3_bounce_key", kif.key, 16'h0000);
    pressed = 16'h0001;
    expq.push_back(16'h0001);
    drain("t3_bounce");
    chk("t3_key", kif.key, 16'h0001);
    settle(3);
    press(16'h0000, "t3_release");

    press(16'h8001, "t4_pair");
    press(16'h0000, "t4_release");

`ifdef KEYPAD_GHOST_REJECT_EN
    align();
    pressed = 16'h0013;
    settle(6);
    chk("t5_ghost_key", kif.key, 16'h0000);
    chk("t5_ghost_any", {15'd0, kif.key_any}, 16'h0000);
    align();
    pressed = 16'h0000;
    settle(4);
    chk("t5_rel_key", kif.key, 16'h0000);
`else
    press(16'h0013, "t5_three");
    press(16'h0000, "t5_release");
`endif

    press(16'h0200, "t6_hold");
    n6 = 0;
    while (kif.row_out != 4'b1011 && n6 < 20) begin
      @(negedge clk1k);
      n6++;
    end
    chk("t6_row2", {12'd0, kif.row_out}, 16'h000B);
    rst_n = 1'b0;
    @(negedge clk1k);
    chk("t6_rst_key", kif.key, 16'h0000);
    chk("t6_rst_row", {12'd0, kif.row_out}, 16'h000E);
    chk("t6_rst_any", {15'd0, kif.key_any}, 16'h0000);
    chk("t6_rst_evt", {15'd0, kif.key_event}, 16'h0000);
    rst_n = 1'b1;
    expq.push_back(16'h0200);
    drain("t6_recover");
    chk("t6_key", kif.key, 16'h0200);
    settle(2);
    press(16'h0000, "t6_release");

    settle(2);
    chk("queue_empty", 16'(expq.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
